// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampled 8-bit UART receiver with optional parity, valid/ready output and error flags
module uart_rx_os16 #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int OS_DIV     = (CLK_FREQ + BAUD*8)/(BAUD*16),
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk_100m,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun_err,
   output logic       rx_busy
);
   localparam int TW = $clog2(OS_DIV);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;
   state_t          state_q;
   logic            rx_m_q, rx_s_q;
   logic [TW-1:0]   tcnt_q;
   logic [3:0]      s_q;
   logic [2:0]      bit_q;
   logic [7:0]      sh_q;
   logic [1:0]      smp_q;
   logic            fe_q, pe_q, load_q;
   logic            tick, vote, mid, end_b;
   assign tick    = tcnt_q == TW'(OS_DIV-1);
   assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
   assign mid     = tick && s_q == 4'd9;
   assign end_b   = tick && s_q == 4'd15;
   assign rx_busy = state_q != S_IDLE;
   // two-flop synchronizer; idles high so reset does not look like a start bit
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         rx_m_q <= rx;
         rx_s_q <= rx_m_q;
      end
   end
   // oversampling, frame FSM and valid/ready output register
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tcnt_q      <= '0;
         s_q         <= '0;
         bit_q       <= '0;
         sh_q        <= '0;
         smp_q       <= '0;
         fe_q        <= 1'b0;
         pe_q        <= 1'b0;
         load_q      <= 1'b0;
         data_out    <= '0;
         valid       <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         load_q <= 1'b0;
         tcnt_q <= (state_q == S_IDLE || tick) ? '0 : tcnt_q + 1'b1;
         if (tick) s_q <= s_q + 1'b1;
         if (tick && s_q == 4'd7) smp_q[0] <= rx_s_q;
         if (tick && s_q == 4'd8) smp_q[1] <= rx_s_q;
         case (state_q)
            S_IDLE: if (!rx_s_q) begin
               state_q <= S_START;
               s_q     <= '0;
               fe_q    <= 1'b0;
               pe_q    <= 1'b0;
            end
            S_START: if (mid && vote) state_q <= S_IDLE;
               else if (end_b) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
               end
            S_DATA: begin
               if (mid) sh_q <= {vote, sh_q[7:1]};
               if (end_b) begin
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= PARITY_EN ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (mid) pe_q <= vote ^ (^sh_q) ^ PARITY_ODD;
               if (end_b) state_q <= S_STOP;
            end
            S_STOP: if (mid) begin
               fe_q    <= !vote;
               load_q  <= 1'b1;
               state_q <= vote ? S_IDLE : S_BRK;
            end
            S_BRK: if (rx_s_q) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (load_q) begin
            data_out    <= sh_q;
            frame_err   <= fe_q;
            parity_err  <= pe_q;
            overrun_err <= valid && !ready;
            valid       <= 1'b1;
         end else if (valid && ready) valid <= 1'b0;
      end
   end
endmodule
